// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, zero-entry masking and
// same-cycle write/clear forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [AW-1:0]    raddr,
    input  logic             byp_en,
    input  logic             we,
    input  logic             clr,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic in_range;
    logic is_zero;
    logic fwd_hit;

    always_comb begin
        in_range = ({1'b0, raddr} < DEPTH_L);
        is_zero  = (ZERO_REG0 != 0) && (raddr == '0);
        fwd_hit  = (BYPASS != 0) && byp_en && (raddr == waddr);
        rdata    = '0;
        if (in_range && !is_zero) begin
            if (fwd_hit && clr) begin
                rdata = '0;
            end else if (fwd_hit && we) begin
                rdata = wdata;
            end else begin
                rdata = mem[raddr];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two combinational read ports, single
// write/clear port and a one-entry-per-cycle clear-all sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clr,
    input  logic             clr_all,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state_reg;
    logic [AW-1:0]    clr_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0] ent_we;
    logic [DEPTH-1:0] ent_zero;
    logic             byp_en;

    // Per-entry write decode; waddr values beyond DEPTH never match an entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic sweep_hit;
            logic wr_hit;
            assign sweep_hit = (state_reg == CLEAR) && (clr_ptr_reg == IDX);
            assign wr_hit    = (state_reg == IDLE) && !clr_all && (waddr == IDX) && (we || clr);
            if (ZERO_REG0 != 0 && gi == 0) begin : g_hard_zero
                assign ent_we[gi]   = 1'b0;
                assign ent_zero[gi] = 1'b1;
            end else begin : g_normal
                assign ent_we[gi]   = sweep_hit || wr_hit;
                assign ent_zero[gi] = sweep_hit || clr;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_we[i]) begin
                    mem_reg[i] <= ent_zero[i] ? '0 : wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            clr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_ptr_reg <= '0;
                    if (clr_all) begin
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_ptr_reg == LAST) begin
                        state_reg   <= IDLE;
                        clr_ptr_reg <= '0;
                    end else begin
                        clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    clr_ptr_reg <= '0;
                end
            endcase
        end
    end

    assign busy   = (state_reg == CLEAR);
    assign byp_en = (state_reg == IDLE) && !clr_all;

    regfile_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG0(ZERO_REG0), .AW(AW)
    ) u_port_a (
        .mem(mem_reg), .raddr(raddr_a), .byp_en(byp_en), .we(we), .clr(clr),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_a)
    );

    regfile_read_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG0(ZERO_REG0), .AW(AW)
    ) u_port_b (
        .mem(mem_reg), .raddr(raddr_b), .byp_en(byp_en), .we(we), .clr(clr),
        .waddr(waddr), .wdata(wdata), .rdata(rdata_b)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three configurations share one stimulus
// stream (bypass depth 8, no-bypass depth 8, bypass depth 6 with zero entry).
module tb_regfile_mp;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       we, clr, clr_all;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rda [3];
    logic [7:0] rdb [3];
    logic       bsy [3];

    localparam int M_D [3] = '{8, 8, 6};
    localparam int M_B [3] = '{1, 0, 1};
    localparam int M_Z [3] = '{0, 0, 1};

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(8), .DEPTH(8), .BYPASS(1), .ZERO_REG0(0)) u_byp (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .clr_all(clr_all), .raddr_a(raddr_a), .rdata_a(rda[0]),
        .raddr_b(raddr_b), .rdata_b(rdb[0]), .busy(bsy[0]));

    regfile_mp #(.WIDTH(8), .DEPTH(8), .BYPASS(0), .ZERO_REG0(0)) u_nobyp (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .clr_all(clr_all), .raddr_a(raddr_a), .rdata_a(rda[1]),
        .raddr_b(raddr_b), .rdata_b(rdb[1]), .busy(bsy[1]));

    regfile_mp #(.WIDTH(8), .DEPTH(6), .BYPASS(1), .ZERO_REG0(1)) u_zero (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .clr(clr), .clr_all(clr_all), .raddr_a(raddr_a), .rdata_a(rda[2]),
        .raddr_b(raddr_b), .rdata_b(rdb[2]), .busy(bsy[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_mem [3][8];
    logic       m_clear [3];
    int         m_ptr [3];

    string      tag_q [$];
    logic [7:0] exp_q [$];
    logic       last_busy;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            m_clear[k] = 1'b0;
            m_ptr[k]   = 0;
        end
    endfunction

    function automatic logic [7:0] m_read(input int k, input logic [2:0] ra);
        if (int'(ra) >= M_D[k]) return 8'h00;
        if (M_Z[k] != 0 && ra == 3'd0) return 8'h00;
        if (M_B[k] != 0 && !m_clear[k] && !clr_all && ra == waddr) begin
            if (clr) return 8'h00;
            if (we) return wdata;
        end
        return m_mem[k][ra];
    endfunction

    function automatic void m_step();
        for (int k = 0; k < 3; k++) begin
            if (!m_clear[k]) begin
                if (clr_all) begin
                    m_clear[k] = 1'b1;
                    m_ptr[k]   = 0;
                end else if (int'(waddr) < M_D[k] && !(M_Z[k] != 0 && waddr == 3'd0)) begin
                    if (clr) m_mem[k][waddr] = 8'h00;
                    else if (we) m_mem[k][waddr] = wdata;
                end
            end else begin
                m_mem[k][m_ptr[k]] = 8'h00;
                if (m_ptr[k] == M_D[k] - 1) begin
                    m_clear[k] = 1'b0;
                    m_ptr[k]   = 0;
                end else begin
                    m_ptr[k]++;
                end
            end
        end
    endfunction

    // One clock cycle: drive, queue expectations, compare at negedge, advance model.
    task automatic cyc(input logic i_we, input logic i_clr, input logic i_ca,
                       input logic [2:0] wa, input logic [7:0] wd,
                       input logic [2:0] a, input logic [2:0] b);
        we = i_we; clr = i_clr; clr_all = i_ca;
        waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
        for (int k = 0; k < 3; k++) begin
            tag_q.push_back($sformatf("i%0d_rda_a%0d", k, a)); exp_q.push_back(m_read(k, a));
            tag_q.push_back($sformatf("i%0d_rdb_a%0d", k, b)); exp_q.push_back(m_read(k, b));
            tag_q.push_back($sformatf("i%0d_busy", k));        exp_q.push_back({7'd0, m_clear[k]});
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_eq(tag_q.pop_front(), rda[k], exp_q.pop_front());
            check_eq(tag_q.pop_front(), rdb[k], exp_q.pop_front());
            check_eq(tag_q.pop_front(), {7'd0, bsy[k]}, exp_q.pop_front());
        end
        last_busy = bsy[0];
        $display("txn t=%0t we=%b clr=%b ca=%b wa=%0d wd=%h ra=%0d rb=%0d | %h/%h %h/%h %h/%h busy=%b%b%b",
                 $time, i_we, i_clr, i_ca, wa, wd, a, b,
                 rda[0], rdb[0], rda[1], rdb[1], rda[2], rdb[2], bsy[0], bsy[1], bsy[2]);
        @(posedge clk);
        m_step();
        #2;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_i%0d_rda", k), rda[k], 8'h00);
            check_eq($sformatf("rst_i%0d_rdb", k), rdb[k], 8'h00);
            check_eq($sformatf("rst_i%0d_busy", k), {7'd0, bsy[k]}, 8'h00);
        end
        m_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        reset_n = 1'b0;
        we = 0; clr = 0; clr_all = 0; waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        m_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("init_i%0d_rda", k), rda[k], 8'h00);
            check_eq($sformatf("init_i%0d_busy", k), {7'd0, bsy[k]}, 8'h00);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        // Write/read-back with crossed port addresses
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 3'(i), 8'hAA + 8'(i), 3'(i), 3'(7 - i));
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 8'h00, 3'(i), 3'(7 - i));

        // Same-cycle forwarding, then clear-over-write priority
        cyc(1, 0, 0, 3, 8'h5C, 3, 3);
        cyc(0, 0, 0, 0, 8'h00, 3, 2);
        cyc(1, 1, 0, 2, 8'hFF, 2, 2);
        cyc(0, 0, 0, 0, 8'h00, 2, 3);

        // Sweep over a full array; writes to entry 7 during it are dropped
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 3'(i), 8'hCC, 0, 7);
        cyc(0, 0, 1, 0, 8'h00, 0, 7);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(i < 8, 0, 0, 7, 8'h11, 3'(i), 7);
            if (last_busy) busy_cnt++;
        end
        check_eq("sweep_busy_cycles", 8'(busy_cnt), 8'd8);
        cyc(0, 0, 0, 0, 8'h00, 7, 6);

        // clr_all held high with concurrent write traffic
        for (int i = 0; i < 20; i++)
            cyc(1, $urandom_range(0, 3) == 0, 1, 3'($urandom_range(0, 7)), 8'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        cyc(0, 0, 0, 0, 8'h00, 0, 1);

        // Reset in the middle of a sweep
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 3'(i), 8'h70 + 8'(i), 3'(i), 0);
        cyc(0, 0, 1, 0, 8'h00, 5, 6);
        cyc(0, 0, 0, 0, 8'h00, 5, 6);
        cyc(0, 0, 0, 0, 8'h00, 5, 6);
        raddr_a = 5; raddr_b = 6;
        async_reset();
        cyc(1, 0, 0, 4, 8'h44, 4, 5);
        cyc(0, 0, 0, 0, 8'h00, 4, 4);

        // Out-of-range and zero-entry handling
        cyc(1, 0, 0, 0, 8'h12, 0, 7);
        cyc(1, 0, 0, 7, 8'h34, 0, 7);
        cyc(1, 0, 0, 6, 8'h56, 6, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 7);
        cyc(0, 0, 0, 0, 8'h00, 6, 5);

        // Random traffic with occasional sweeps
        for (int i = 0; i < 80; i++)
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 15) == 0,
                3'($urandom_range(0, 7)), 8'($urandom),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
